// File: rtl/button_press_classifier.sv
// ----------------------------------------------------------------------------
// button_press_classifier
//
// Turns the debounced push-button level into clean, clock-aligned events for
// the downstream control FSMs. Each physical press produces exactly one
// press_pulse. Depending on how long the button is held, the press then ends
// in one short_pulse, or in one long_pulse followed by optional auto-repeat
// pulses for as long as the button stays down.
//
// Parameters:
//   LONG_CYCLES   - held edges (counting the press-start edge) at which a
//                   press becomes long; must be >= 2
//   REPEAT_CYCLES - further held edges between auto-repeat pulses; >= 1
//   REPEAT_EN     - 1 enables auto-repeat, 0 keeps rpt_pulse low
//
// Ports:
//   clk         - system clock, all logic on the rising edge
//   rst         - asynchronous, active-low reset
//   db_in       - debounced button level, synchronous to clk, 1 = pressed
//   press_pulse - one-cycle pulse when a press starts
//   short_pulse - one-cycle pulse on release of a short press
//   long_pulse  - one-cycle pulse when a press reaches LONG_CYCLES
//   rpt_pulse   - one-cycle pulse every REPEAT_CYCLES edges while held long
//   held        - level, 1 while the press is classified long and still held
// ----------------------------------------------------------------------------
module button_press_classifier #(
    parameter int unsigned LONG_CYCLES   = 8,
    parameter int unsigned REPEAT_CYCLES = 4,
    parameter bit          REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic db_in,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic rpt_pulse,
    output logic held
);

    // The counter must be able to hold the larger of the two thresholds.
    localparam int unsigned MAX_COUNT = (LONG_CYCLES > REPEAT_CYCLES) ?
                                        LONG_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CW        = $clog2(MAX_COUNT + 1);

    localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
    localparam logic [CW-1:0] RPT_C  = CW'(REPEAT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS,
        ST_HOLD
    } state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;
    logic          db_prev_q;
    logic          press_q;
    logic          short_q;
    logic          long_q;
    logic          rpt_q;
    logic          held_q;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    always_comb begin
        cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
    end

    // NOTE: every register in this block is assigned with <= so all of them
    // update together from the values sampled before the edge; a blocking
    // assignment would let later statements see half-updated state.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: every flop, outputs included, is cleared by the asynchronous
        // reset so the outputs drop the moment rst falls, not at the next edge.
        if (!rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            db_prev_q <= 1'b0;
            press_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            db_prev_q <= db_in;
            // Pulses default low so each one lasts exactly one cycle.
            press_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            rpt_q     <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    // Rising edge of the sampled level starts a press; the
                    // start edge itself counts as the first held edge.
                    if (db_in && !db_prev_q) begin
                        press_q <= 1'b1;
                        cnt_q   <= CW'(1);
                        state_q <= ST_PRESS;
                    end
                end

                ST_PRESS: begin
                    if (db_in) begin
                        if (cnt_inc == LONG_C) begin
                            long_q  <= 1'b1;
                            held_q  <= 1'b1;
                            cnt_q   <= '0;
                            state_q <= ST_HOLD;
                        end else begin
                            cnt_q <= cnt_inc;
                        end
                    end else begin
                        short_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end

                ST_HOLD: begin
                    if (db_in) begin
                        if (REPEAT_EN) begin
                            if (cnt_inc == RPT_C) begin
                                rpt_q <= 1'b1;
                                cnt_q <= '0;
                            end else begin
                                cnt_q <= cnt_inc;
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end else begin
                        // Releasing a long press ends silently.
                        held_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_IDLE;
                    end
                end

                default: begin
                    held_q  <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign press_pulse = press_q;
    assign short_pulse = short_q;
    assign long_pulse  = long_q;
    assign rpt_pulse   = rpt_q;
    assign held        = held_q;

endmodule

// File: tb/tb_button_press_classifier.sv
// ----------------------------------------------------------------------------
// tb_button_press_classifier
//
// Directed bench for button_press_classifier with LONG_CYCLES=8 and
// REPEAT_CYCLES=4. Two instances share clock, reset and button input: dut_r
// has auto-repeat enabled, dut_n has it disabled. Outputs are compared as a
// 5-bit vector {press, short, long, rpt, held} one time unit after each edge.
// ----------------------------------------------------------------------------
module tb_button_press_classifier;

    logic clk;
    logic rst;
    logic db_in;

    logic press_r, short_r, long_r, rpt_r, held_r;
    logic press_n, short_n, long_n, rpt_n, held_n;

    int total;
    int bad;

    button_press_classifier #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .REPEAT_EN    (1'b1)
    ) dut_r (
        .clk        (clk),
        .rst        (rst),
        .db_in      (db_in),
        .press_pulse(press_r),
        .short_pulse(short_r),
        .long_pulse (long_r),
        .rpt_pulse  (rpt_r),
        .held       (held_r)
    );

    button_press_classifier #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .REPEAT_EN    (1'b0)
    ) dut_n (
        .clk        (clk),
        .rst        (rst),
        .db_in      (db_in),
        .press_pulse(press_n),
        .short_pulse(short_n),
        .long_pulse (long_n),
        .rpt_pulse  (rpt_n),
        .held       (held_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [4:0] obs_r();
        return {press_r, short_r, long_r, rpt_r, held_r};
    endfunction

    function automatic logic [4:0] obs_n();
        return {press_n, short_n, long_n, rpt_n, held_n};
    endfunction

    // Expected {press, short, long, rpt, held} after edge k of a press that is
    // high for edges 1..n and low at edge n+1 (LONG=8, REPEAT=4).
    function automatic logic [4:0] exp_vec(input int k, input int n, input bit en);
        logic [4:0] e;
        e = 5'b00000;
        if (k == 1) e[4] = 1'b1;
        if (k <= n) begin
            if (k == 8) begin
                e[2] = 1'b1;
                e[0] = 1'b1;
            end else if (k > 8) begin
                e[0] = 1'b1;
                if (en && ((k - 8) % 4 == 0)) e[1] = 1'b1;
            end
        end else if (n < 8) begin
            e[3] = 1'b1;
        end
        return e;
    endfunction

    // Drive the button level, let one rising edge pass, settle 1 time unit.
    task automatic tick(input logic v);
        db_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        db_in = 1'b1;
        tick(1'b1);
        total++;
        if (obs_r() !== 5'b00000) begin
            bad++;
            $display("FAIL reset_hold_r: got %b expected %b", obs_r(), 5'b00000);
        end
        total++;
        if (obs_n() !== 5'b00000) begin
            bad++;
            $display("FAIL reset_hold_n: got %b expected %b", obs_n(), 5'b00000);
        end
        db_in = 1'b0;
        rst   = 1'b1;
        tick(1'b0);
        total++;
        if (obs_r() !== 5'b00000) begin
            bad++;
            $display("FAIL reset_idle: got %b expected %b", obs_r(), 5'b00000);
        end
    endtask

    // Runs a press of n high edges plus the release edge on both instances.
    task automatic test_press_len(input string name, input int n);
        for (int k = 1; k <= n + 1; k++) begin
            tick(k <= n);
            total++;
            if (obs_r() !== exp_vec(k, n, 1'b1)) begin
                bad++;
                $display("FAIL %s_r edge %0d: got %b expected %b", name, k, obs_r(), exp_vec(k, n, 1'b1));
            end
            total++;
            if (obs_n() !== exp_vec(k, n, 1'b0)) begin
                bad++;
                $display("FAIL %s_n edge %0d: got %b expected %b", name, k, obs_n(), exp_vec(k, n, 1'b0));
            end
        end
        tick(1'b0);
        total++;
        if (obs_r() !== 5'b00000) begin
            bad++;
            $display("FAIL %s_quiet: got %b expected %b", name, obs_r(), 5'b00000);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0]  stim;
        logic [4:0]  exp_tab [6];
        stim = 6'b101110;  // applied from bit 5 down: 1,0,1,1,1,0
        exp_tab[0] = 5'b10000;
        exp_tab[1] = 5'b01000;
        exp_tab[2] = 5'b10000;
        exp_tab[3] = 5'b00000;
        exp_tab[4] = 5'b00000;
        exp_tab[5] = 5'b01000;
        for (int i = 0; i < 6; i++) begin
            tick(stim[5 - i]);
            total++;
            if (obs_r() !== exp_tab[i]) begin
                bad++;
                $display("FAIL back_to_back edge %0d: got %b expected %b", i + 1, obs_r(), exp_tab[i]);
            end
        end
        tick(1'b0);
    endtask

    task automatic test_reset_mid_press();
        // Hold for 10 edges: long at edge 8, held afterwards.
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            total++;
            if (obs_r() !== exp_vec(k, 20, 1'b1)) begin
                bad++;
                $display("FAIL pre_reset edge %0d: got %b expected %b", k, obs_r(), exp_vec(k, 20, 1'b1));
            end
        end
        // Asynchronous reset between edges, button still pressed.
        rst = 1'b0;
        #1;
        total++;
        if (obs_r() !== 5'b00000) begin
            bad++;
            $display("FAIL async_clear_r: got %b expected %b", obs_r(), 5'b00000);
        end
        total++;
        if (obs_n() !== 5'b00000) begin
            bad++;
            $display("FAIL async_clear_n: got %b expected %b", obs_n(), 5'b00000);
        end
        #1;
        rst = 1'b1;
        // The first edge after release must look like a fresh press start.
        for (int k = 1; k <= 9; k++) begin
            tick(k <= 8);
            total++;
            if (obs_r() !== exp_vec(k, 8, 1'b1)) begin
                bad++;
                $display("FAIL post_reset edge %0d: got %b expected %b", k, obs_r(), exp_vec(k, 8, 1'b1));
            end
        end
        tick(1'b0);
        // Single-cycle high: press, then short on the next edge.
        tick(1'b1);
        total++;
        if (obs_r() !== 5'b10000) begin
            bad++;
            $display("FAIL single_press: got %b expected %b", obs_r(), 5'b10000);
        end
        tick(1'b0);
        total++;
        if (obs_r() !== 5'b01000) begin
            bad++;
            $display("FAIL single_short: got %b expected %b", obs_r(), 5'b01000);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        db_in = 1'b0;
        test_reset();
        test_press_len("short3", 3);
        test_press_len("short7", 7);
        test_press_len("long8", 8);
        test_press_len("repeat16", 16);
        test_press_len("single1", 1);
        test_back_to_back();
        test_reset_mid_press();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_press_classifier.md
Name: button_press_classifier

Overview:
- Consumes the registered, debounced push-button level produced by the debounce stage.
- Converts that level into single-cycle event pulses: press, short press, long press and auto-repeat while held.
- Also drives a "held" level output.
- Feeds the lab's control FSMs (mode select, counter increment), so each physical press yields exactly one clean, clock-aligned event.

Parameters:
- LONG_CYCLES, 8: number of consecutive sampled-high clock edges at which a press is classified long. Legal range ≥ 2.
- REPEAT_CYCLES, 4: number of further held edges between auto-repeat pulses after a long press. Legal range ≥ 1.
- REPEAT_EN, 1: 1 = auto-repeat enabled; 0 = rpt_pulse is never asserted.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-low reset.
- db_in  input  1  debounced button level from the debounce stage; synchronous to clk; 1 = pressed.
- press_pulse  output  1  one-cycle pulse on each press start.
- short_pulse  output  1  one-cycle pulse on release of a short press.
- long_pulse  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
- rpt_pulse  output  1  one-cycle pulse every REPEAT_CYCLES edges while held after long.
- held  output  1  level; 1 while in HOLD state.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; counter=0; previous-sample register db_d=0.
  - All outputs 0 immediately, held until rst=1.
- All outputs are registered. A pulse is high for exactly the one cycle following the clock edge that caused it.
- Counter:
  - Width $clog2(max(LONG_CYCLES, REPEAT_CYCLES)+1).
  - Saturates and never wraps.
- Edge/press detection:
  - A press starts at an edge where db_in=1 and db_d=0.
  - press_pulse is asserted after that edge.
  - db_d updates every edge.
- States:
  - IDLE:
    - On press start → PRESS, counter=1.
  - PRESS:
    - Each edge with db_in=1: counter+1.
    - If the new count equals LONG_CYCLES: long_pulse, held=1, counter=0, → HOLD.
    - Edge with db_in=0 (count 1..LONG_CYCLES-1): short_pulse, → IDLE, counter=0.
  - HOLD:
    - Each edge with db_in=1: counter+1.
    - When the count reaches REPEAT_CYCLES and REPEAT_EN=1: rpt_pulse, counter=0.
    - If REPEAT_EN=0: the counter holds at 0 and no pulse is produced.
    - Edge with db_in=0: → IDLE, held=0, counter=0. No short_pulse, no long_pulse.
- Boundary conditions:
  - A single-cycle high on db_in is a valid press: press_pulse, then short_pulse on the next edge.
  - Release on the same edge the count would reach LONG_CYCLES is impossible: that edge samples 0, so the press is short.
  - Re-press the edge after a release: a new press starts normally, because db_d=0.
  - Reset mid-press: everything clears. If db_in=1 when rst deasserts, the first edge is treated as a new press start (db_d was reset to 0).
  - At most one of short_pulse, long_pulse, rpt_pulse is high in any cycle.
  - press_pulse never coincides with long_pulse (LONG_CYCLES ≥ 2).

Test Plan (LONG_CYCLES=8, REPEAT_CYCLES=4, REPEAT_EN=1 unless noted):
1. db_in high for edges 1–3, low at edge 4 → press_pulse after edge 1; short_pulse after edge 4; no long_pulse; held stays 0.
2. db_in high for edges 1–7, low at edge 8 → short_pulse after edge 8; long_pulse never asserted.
3. db_in high for edges 1–8, low at edge 9 → long_pulse after edge 8; held=1 after edges 8–9 window; held=0 after edge 9; no short_pulse.
4. db_in high for edges 1–16 → long_pulse after edge 8; rpt_pulse after edges 12 and 16; held=1 from edge 8.
5. Same as 4 with REPEAT_EN=0 → long_pulse after edge 8; rpt_pulse stays 0.
6. db_in held high; rst pulsed low between edges 10 and 11, then released with db_in still 1:
   - All outputs go to 0 immediately when rst falls.
   - press_pulse after the first edge following release.
   - long_pulse after 8 edges from that point.
   - Single-cycle high on db_in afterwards → press_pulse, then short_pulse on the next cycle.
